// File: rtl/ruler_search_controller_pkg.sv
// Shared widths, FSM encodings and decision helpers for the ruler search controller.
// The `Ctl* and width macros stand in for the definitions.v entries when that file is absent.
`ifndef PositionValueBitMax
`define PositionValueBitMax 7
`endif
`ifndef PositionNumberBitMax
`define PositionNumberBitMax 3
`endif
`ifndef NUMPOSITIONS
`define NUMPOSITIONS 4
`endif
`ifndef FirstVariablePosition
`define FirstVariablePosition 2
`endif
`ifndef CtlStateIdle
`define CtlStateIdle     3'd0
`define CtlStateInit     3'd1
`define CtlStateIssue    3'd2
`define CtlStateWaitLow  3'd3
`define CtlStateWaitHigh 3'd4
`define CtlStateEval     3'd5
`define CtlStateSolution 3'd6
`define CtlStateDone     3'd7
`endif
`ifndef CtlRestrobe
`define CtlRestrobe 8
`endif

package ruler_search_controller_pkg;

    localparam int PVW = `PositionValueBitMax + 1;
    localparam int PNW = `PositionNumberBitMax + 1;

    localparam logic [2:0] ST_IDLE      = `CtlStateIdle;
    localparam logic [2:0] ST_INIT      = `CtlStateInit;
    localparam logic [2:0] ST_ISSUE     = `CtlStateIssue;
    localparam logic [2:0] ST_WAIT_LOW  = `CtlStateWaitLow;
    localparam logic [2:0] ST_WAIT_HIGH = `CtlStateWaitHigh;
    localparam logic [2:0] ST_EVAL      = `CtlStateEval;
    localparam logic [2:0] ST_SOLUTION  = `CtlStateSolution;
    localparam logic [2:0] ST_DONE      = `CtlStateDone;

    // Last value of the wait counter before re-strobing: the ISSUE cycle plus
    // counts 0..RESTROBE_LAST give one request every RESTROBE_LAST+2 clocks.
    localparam logic [3:0] RESTROBE_LAST = 4'(`CtlRestrobe);

    // A level that wrapped below zero reads as all-ones and means the search is exhausted.
    function automatic logic level_exhausted(input logic [PNW-1:0] lvl,
                                             input logic [PNW-1:0] first);
        return (lvl == {PNW{1'b1}}) || (lvl < first);
    endfunction

    function automatic logic level_complete(input logic [PNW-1:0] lvl,
                                            input logic [PNW-1:0] last);
        return lvl > last;
    endfunction

endpackage

// File: rtl/ruler_search_controller.sv
// Sequencer that hands control between Golomb-ruler mark counters and reports rulers.
// Define LIMIT_TIGHTEN_EN to shrink the length bound to each ruler found.
module ruler_search_controller
    import ruler_search_controller_pkg::*;
#(
    parameter int NUMPOS   = `NUMPOSITIONS,
    parameter int FIRSTVAR = `FirstVariablePosition
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           start,
    input  logic [PVW-1:0] init_limit,
    output logic           marks_reset,
    output logic [PNW-1:0] enabled,
    output logic           request,
    input  logic           mark_ready,
    input  logic [PNW-1:0] next_enabled,
    input  logic [PVW-1:0] last_val,
    output logic [PVW-1:0] limit,
    output logic           solution_valid,
    output logic [PVW-1:0] solution_length,
    output logic           busy,
    output logic           done
);

    localparam logic [PNW-1:0] NUMPOS_W = PNW'(NUMPOS);
    localparam logic [PNW-1:0] FIRST_W  = PNW'(FIRSTVAR);

    logic [2:0] state;
    logic [3:0] wait_cnt;
    logic       rst_hold;

    // Marks stay in reset from our reset until the first clean edge, and again during INIT.
    assign marks_reset = rst_hold | (state == ST_INIT);
    assign request     = (state == ST_ISSUE);

    always_ff @(posedge clock) begin
        if (!reset) begin
            state           <= ST_IDLE;
            wait_cnt        <= '0;
            rst_hold        <= 1'b1;
            enabled         <= '0;
            limit           <= '0;
            solution_length <= '0;
            solution_valid  <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
        end else begin
            rst_hold       <= 1'b0;
            solution_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        limit   <= init_limit;
                        busy    <= 1'b1;
                        done    <= 1'b0;
                        enabled <= FIRST_W;
                        state   <= ST_INIT;
                    end
                end
                ST_INIT: state <= ST_ISSUE;
                ST_ISSUE: begin
                    wait_cnt <= '0;
                    state    <= ST_WAIT_LOW;
                end
                ST_WAIT_LOW: begin
                    if (!mark_ready) begin
                        state <= ST_WAIT_HIGH;
                    end else if (wait_cnt == RESTROBE_LAST) begin
                        state <= ST_ISSUE;
                    end else begin
                        wait_cnt <= wait_cnt + 4'd1;
                    end
                end
                ST_WAIT_HIGH: begin
                    if (mark_ready) begin
                        state <= ST_EVAL;
                    end
                end
                ST_EVAL: begin
                    // Exhaustion is tested first so a wrapped (all-ones) level never counts as complete.
                    if (level_exhausted(next_enabled, FIRST_W)) begin
                        state <= ST_DONE;
                    end else if (level_complete(next_enabled, NUMPOS_W)) begin
                        state <= ST_SOLUTION;
                    end else begin
                        enabled <= next_enabled;
                        state   <= ST_ISSUE;
                    end
                end
                ST_SOLUTION: begin
                    solution_length <= last_val;
                    solution_valid  <= 1'b1;
                    enabled         <= NUMPOS_W;
`ifdef LIMIT_TIGHTEN_EN
                    limit           <= last_val;
`endif
                    state           <= ST_ISSUE;
                end
                ST_DONE: begin
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
